// File: rtl/sm4_bist_pkg.sv
// Shared types and SM4 known-answer constants for the SM4 self-test engine.
// Holds the controller state encoding plus the standard SM4 test vectors.
// Everything here is compile-time only; no logic lives in the package.
package sm4_bist_pkg;

  // Controller phases of one self-test run.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_KWAIT = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } bist_state_t;

  // Standard SM4 example: the key and the first plaintext are the same block.
  localparam logic [127:0] SM4_KAT_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] SM4_KAT_PT  = 128'h0123456789ABCDEFFEDCBA9876543210;

  // Ciphertext after one encryption of SM4_KAT_PT under SM4_KAT_KEY.
  localparam logic [127:0] SM4_KAT_CT_1  = 128'h681EDF34D206965E86B3E94F536E4246;

  // Ciphertext after 1,000,000 chained encryptions of the same vector.
  localparam logic [127:0] SM4_KAT_CT_1M = 128'h595298C7C6FD271F0402F804C33D3F66;
  localparam int unsigned  SM4_KAT_ITER_1M = 1000000;

  // Width of a counter that must represent values 0..n inclusive, never zero.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sm4_kat_bist.sv
// Known-answer self-test engine: loads the key, runs NUM_ITER chained SM4 encryptions, checks the result.
// Latency: first data strobe KEY_LAT+2 cycles after START; 2 cycles of overhead per iteration beyond the core.
// Backpressure: one block in flight; waits for the core's ready strobe, aborting after TIMEOUT idle cycles.
module sm4_kat_bist
  import sm4_bist_pkg::*;
#(
  parameter logic [127:0] KEY       = SM4_KAT_KEY,
  parameter logic [127:0] PLAINTEXT = SM4_KAT_PT,
  parameter logic [127:0] EXPECTED  = SM4_KAT_CT_1,
  parameter int unsigned  NUM_ITER  = 1,
  parameter int unsigned  KEY_LAT   = 32,
  parameter int unsigned  TIMEOUT   = 1024,
  localparam int unsigned ITER_W    = $clog2(NUM_ITER + 1)
) (
  input  logic              CLK_i,
  input  logic              RST_N_i,
  input  logic              START_i,
  output logic [127:0]      MK_o,
  output logic              MK_VALID_o,
  output logic [127:0]      DAT_o,
  output logic              DAT_VALID_o,
  input  logic [127:0]      DAT_i,
  input  logic              DAT_READY_i,
  output logic              BUSY_o,
  output logic              DONE_o,
  output logic              PASS_o,
  output logic              TIMEOUT_o,
  output logic [ITER_W-1:0] ITER_CNT_o,
  output logic [127:0]      RESULT_o
);

  // Counter widths: the key-wait counter only needs to reach KEY_LAT-1,
  // the timeout counter is sized to hold TIMEOUT so saturation is explicit.
  localparam int unsigned KW = cnt_width(KEY_LAT);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [KW-1:0]     KLAST = KW'(KEY_LAT - 1);
  localparam logic [TW-1:0]     TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]     TMAX  = TW'(TIMEOUT);
  localparam logic [ITER_W-1:0] ILAST = ITER_W'(NUM_ITER - 1);

  bist_state_t       state;
  logic [127:0]      block;
  logic [KW-1:0]     kcnt;
  logic [TW-1:0]     tcnt;
  logic [ITER_W-1:0] iter_cnt;

  // The key never changes; the block register is what the core sees.
  assign MK_o       = KEY;
  assign DAT_o      = block;
  assign ITER_CNT_o = iter_cnt;

  // Run controller: every output strobe and flag is registered from the next-state decision.
  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      state       <= ST_IDLE;
      block       <= PLAINTEXT;
      kcnt        <= '0;
      tcnt        <= '0;
      iter_cnt    <= '0;
      MK_VALID_o  <= 1'b0;
      DAT_VALID_o <= 1'b0;
      BUSY_o      <= 1'b0;
      DONE_o      <= 1'b0;
      PASS_o      <= 1'b0;
      TIMEOUT_o   <= 1'b0;
      RESULT_o    <= '0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      MK_VALID_o  <= 1'b0;
      DAT_VALID_o <= 1'b0;

      case (state)
        // START is honoured only when no run is in progress; a restart from
        // DONE clears the verdict but keeps the last captured ciphertext.
        ST_IDLE, ST_DONE: begin
          if (START_i) begin
            state      <= ST_KEY;
            block      <= PLAINTEXT;
            kcnt       <= '0;
            iter_cnt   <= '0;
            PASS_o     <= 1'b0;
            TIMEOUT_o  <= 1'b0;
            DONE_o     <= 1'b0;
            BUSY_o     <= 1'b1;
            MK_VALID_o <= 1'b1;
          end
        end

        // Key strobe is out this cycle; start waiting for the key schedule.
        ST_KEY: begin
          state <= ST_KWAIT;
        end

        // Give the core KEY_LAT cycles to expand the key before any data.
        ST_KWAIT: begin
          if (kcnt == KLAST) begin
            state       <= ST_ISSUE;
            DAT_VALID_o <= 1'b1;
          end else begin
            kcnt <= kcnt + KW'(1);
          end
        end

        // Data strobe is out this cycle; arm a fresh response window.
        ST_ISSUE: begin
          state <= ST_WAIT;
          tcnt  <= '0;
        end

        // A response in the final window cycle still counts: ready is tested
        // before the expiry comparison.
        ST_WAIT: begin
          if (DAT_READY_i) begin
            block    <= DAT_i;
            RESULT_o <= DAT_i;
            iter_cnt <= iter_cnt + ITER_W'(1);
            if (iter_cnt == ILAST) begin
              state  <= ST_DONE;
              DONE_o <= 1'b1;
              BUSY_o <= 1'b0;
              PASS_o <= (DAT_i == EXPECTED);
            end else begin
              state       <= ST_ISSUE;
              DAT_VALID_o <= 1'b1;
            end
          end else if (tcnt == TLAST) begin
            state     <= ST_DONE;
            DONE_o    <= 1'b1;
            BUSY_o    <= 1'b0;
            TIMEOUT_o <= 1'b1;
            PASS_o    <= 1'b0;
          end else if (tcnt != TMAX) begin
            tcnt <= tcnt + TW'(1);
          end
        end

        default: begin
          state  <= ST_IDLE;
          BUSY_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_kat_bist.sv
// Bench for sm4_kat_bist with a stand-in core: exact SM4 answer for the standard vector, +1 otherwise.
// A timeline model predicts every output each cycle; directed runs add hand-computed literal checks.
// Stand-in core latency, response budget and corruption are set per run.
module tb_sm4_kat_bist;

  localparam logic [127:0] KEY_LIT = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] PT_LIT  = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] CT1_LIT = 128'h681EDF34D206965E86B3E94F536E4246;
  // Three chained stand-in encryptions: CT1, CT1+1, CT1+2.
  localparam logic [127:0] EXP3    = 128'h681EDF34D206965E86B3E94F536E4248;
  // Same chain with bit 0 flipped on every response: 4247, 4249, 424B.
  localparam logic [127:0] BAD3    = 128'h681EDF34D206965E86B3E94F536E424B;

  localparam int N_IT = 3;
  localparam int KL   = 4;
  localparam int TO   = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] mk;
  logic         mk_valid;
  logic [127:0] dat;
  logic         dat_valid;
  logic [127:0] dat_in;
  logic         dat_ready;
  logic         busy;
  logic         done;
  logic         pass;
  logic         tmo;
  logic [1:0]   iter_cnt;
  logic [127:0] result;

  int total = 0;
  int bad   = 0;

  sm4_kat_bist #(
    .KEY(KEY_LIT), .PLAINTEXT(PT_LIT), .EXPECTED(EXP3),
    .NUM_ITER(N_IT), .KEY_LAT(KL), .TIMEOUT(TO)
  ) dut (
    .CLK_i(clk), .RST_N_i(rst_n), .START_i(start),
    .MK_o(mk), .MK_VALID_o(mk_valid),
    .DAT_o(dat), .DAT_VALID_o(dat_valid),
    .DAT_i(dat_in), .DAT_READY_i(dat_ready),
    .BUSY_o(busy), .DONE_o(done), .PASS_o(pass), .TIMEOUT_o(tmo),
    .ITER_CNT_o(iter_cnt), .RESULT_o(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] fake_core(input logic [127:0] x);
    return (x == PT_LIT) ? CT1_LIT : x + 128'd1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- stand-in core ----------------
  int           stub_lat     = 5;
  int           stub_budget  = 1000;
  logic         stub_corrupt = 1'b0;
  logic         spur         = 1'b0;
  int           stub_cd      = 0;
  logic [127:0] stub_resp    = '0;

  initial begin
    dat_ready = 1'b0;
    dat_in    = '0;
    forever begin
      @(negedge clk);
      dat_ready = 1'b0;
      if (stub_cd > 0) begin
        stub_cd--;
        if (stub_cd == 0) begin
          dat_ready = 1'b1;
          dat_in    = stub_resp;
        end
      end
      if (spur) begin
        dat_ready = 1'b1;
        dat_in    = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        spur      = 1'b0;
      end
      if (dat_valid && stub_budget > 0) begin
        stub_budget--;
        stub_cd   = stub_lat;
        stub_resp = fake_core(dat) ^ {127'd0, stub_corrupt};
      end
    end
  end

  // ---------------- timeline model ----------------
  // cyc = number of the last rising edge; outputs are predicted for the
  // interval after that edge.
  int           cyc       = 0;
  logic         m_busy    = 1'b0;
  logic         m_done    = 1'b0;
  logic         m_pass    = 1'b0;
  logic         m_to      = 1'b0;
  int           m_iter    = 0;
  logic [127:0] m_block   = PT_LIT;
  logic [127:0] m_result  = '0;
  int           key_win   = -100;
  int           issue_win = -100;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 0; m_done = 0; m_pass = 0; m_to = 0; m_iter = 0;
        m_block = PT_LIT; m_result = '0; key_win = -100; issue_win = -100;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_done = 0; m_pass = 0; m_to = 0; m_iter = 0;
          m_block = PT_LIT;
          key_win   = cyc;
          issue_win = cyc + 1 + KL;
        end
      end else if (cyc >= issue_win + 2) begin
        // The sampled inputs belong to a response-window cycle.
        if (dat_ready) begin
          m_block  = dat_in;
          m_result = dat_in;
          m_iter++;
          if (m_iter == N_IT) begin
            m_busy = 0; m_done = 1; m_pass = (dat_in == EXP3);
          end else begin
            issue_win = cyc;
          end
        end else if (cyc == issue_win + TO + 1) begin
          m_busy = 0; m_done = 1; m_to = 1; m_pass = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [391:0] exp_v;
    logic [391:0] act_v;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_v = {m_busy && (cyc == key_win), m_busy && (cyc == issue_win),
               m_busy, m_done, m_pass, m_to, 2'(m_iter), KEY_LIT, m_block, m_result};
      act_v = {mk_valid, dat_valid, busy, done, pass, tmo, iter_cnt, mk, dat, result};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL cycle_outputs at edge %0d: got %h want %h", cyc, act_v, exp_v);
      end
    end
  end

  // ---------------- directed runs ----------------
  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n_dv);
    int n;
    n = 0;
    n_dv = 0;
    while (!done && n < 400) begin
      if (dat_valid) n_dv++;
      @(negedge clk);
      n++;
    end
    chk("done_reached", 128'(done), 128'd1);
  endtask

  initial begin
    int n;
    int n_dv;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_dat_o",  dat, PT_LIT);
    chk("rst_mk_o",   mk, KEY_LIT);
    chk("rst_busy",   128'(busy), 128'd0);
    chk("rst_result", result, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray ready while idle changes nothing.
    spur = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_spur_result", result, 128'd0);
    chk("idle_spur_iter",   128'(iter_cnt), 128'd0);

    // Normal run with latency measurement.
    stub_lat = 5;
    start_pulse();
    chk("key_strobe", 128'(mk_valid), 128'd1);
    n = 1;
    while (!dat_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("first_issue_lat", 128'(n), 128'(KL + 2));
    wait_done(n_dv);
    chk("run1_issues", 128'(n_dv), 128'd3);
    chk("run1_pass",   128'(pass), 128'd1);
    chk("run1_tmo",    128'(tmo), 128'd0);
    chk("run1_iter",   128'(iter_cnt), 128'd3);
    chk("run1_result", result, EXP3);

    // START held through a whole run, raised while in DONE.
    start = 1'b1;
    @(negedge clk);
    chk("restart_clears_done", 128'(done), 128'd0);
    n = 0;
    n_dv = 0;
    while (!done && n < 400) begin
      if (dat_valid) n_dv++;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("held_done",   128'(done), 128'd1);
    chk("held_issues", 128'(n_dv), 128'd3);
    chk("held_result", result, EXP3);
    @(negedge clk);
    chk("held_no_rerun", 128'(busy), 128'd0);

    // Wrong ciphertext from the core.
    stub_corrupt = 1'b1;
    start_pulse();
    wait_done(n_dv);
    stub_corrupt = 1'b0;
    chk("bad_pass",   128'(pass), 128'd0);
    chk("bad_tmo",    128'(tmo), 128'd0);
    chk("bad_result", result, BAD3);

    // Core answers once, then goes silent.
    stub_budget = 1;
    stub_lat    = 3;
    start_pulse();
    n = 0;
    n_dv = 0;
    while (n_dv < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (dat_valid) n_dv++;
    end
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_rise",   128'(n), 128'(TO + 1));
    chk("timeout_flag",   128'(tmo), 128'd1);
    chk("timeout_pass",   128'(pass), 128'd0);
    chk("timeout_iter",   128'(iter_cnt), 128'd1);
    chk("timeout_result", result, CT1_LIT);
    stub_budget = 1000;

    // Response exactly in the expiry cycle wins.
    stub_lat = TO;
    start_pulse();
    wait_done(n_dv);
    chk("expiry_tmo",  128'(tmo), 128'd0);
    chk("expiry_pass", 128'(pass), 128'd1);

    // Response one cycle too late: timeout, and the late strobe is ignored.
    stub_lat = TO + 1;
    start_pulse();
    wait_done(n_dv);
    chk("late_tmo", 128'(tmo), 128'd1);
    repeat (3) @(negedge clk);
    chk("late_iter",   128'(iter_cnt), 128'd0);
    chk("late_result", result, EXP3);

    // Reset while waiting for the core.
    stub_lat = 10;
    start_pulse();
    n = 0;
    while (!dat_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("wait_rst_busy",   128'(busy), 128'd0);
    chk("wait_rst_dv",     128'(dat_valid), 128'd0);
    chk("wait_rst_dat",    dat, PT_LIT);
    chk("wait_rst_result", result, 128'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    spur = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_result", result, 128'd0);
    stub_lat = 2;
    start_pulse();
    wait_done(n_dv);
    chk("post_rst_pass",   128'(pass), 128'd1);
    chk("post_rst_result", result, EXP3);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
